// File: rtl/rgb_pwm_driver.sv
// ============================================================================
// rgb_pwm_driver : three-channel active-low RGB PWM driver, period-aligned loads
// Revision: 1.0
// ============================================================================
`default_nettype none

module rgb_pwm_driver #(
    parameter int PRESCALE = 256,
    parameter int PWM_BITS = 8
) (
    input  logic                clk_24MHz_i,
    input  logic                rst_n_i,
    input  logic                color_valid_i,
    output logic                color_ready_o,
    input  logic [PWM_BITS-1:0] color_r_i,
    input  logic [PWM_BITS-1:0] color_g_i,
    input  logic [PWM_BITS-1:0] color_b_i,
    input  logic                enable_i,
    output logic                period_start_o,
    output logic                LED_R_n_o,
    output logic                LED_G_n_o,
    output logic                LED_B_n_o
);

    localparam int                  c_ps_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_ps_w-1:0]   c_ps_max  = c_ps_w'(PRESCALE - 1);
    localparam logic [c_ps_w-1:0]   c_ps_one  = c_ps_w'(1);
    localparam logic [PWM_BITS-1:0] c_cnt_max = '1;
    localparam logic [PWM_BITS-1:0] c_cnt_one = PWM_BITS'(1);

    logic [c_ps_w-1:0]   prescaler_q, prescaler_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] active_r_q, active_r_d;
    logic [PWM_BITS-1:0] active_g_q, active_g_d;
    logic [PWM_BITS-1:0] active_b_q, active_b_d;
    logic [PWM_BITS-1:0] pend_r_q, pend_r_d;
    logic [PWM_BITS-1:0] pend_g_q, pend_g_d;
    logic [PWM_BITS-1:0] pend_b_q, pend_b_d;
    logic                pending_q, pending_d;
    logic                ready_q, ready_d;
    logic                period_start_q, period_start_d;
    logic                led_r_n_q, led_r_n_d;
    logic                led_g_n_q, led_g_n_d;
    logic                led_b_n_q, led_b_n_d;

    logic w_tick;
    logic w_boundary;
    logic w_accept;

    assign w_tick     = (prescaler_q == c_ps_max);
    assign w_boundary = w_tick && (pwm_cnt_q == c_cnt_max);
    assign w_accept   = color_valid_i && ready_q;

    always_comb begin
        prescaler_d    = w_tick ? '0 : prescaler_q + c_ps_one;
        pwm_cnt_d      = w_tick ? pwm_cnt_q + c_cnt_one : pwm_cnt_q;
        active_r_d     = active_r_q;
        active_g_d     = active_g_q;
        active_b_d     = active_b_q;
        pend_r_d       = pend_r_q;
        pend_g_d       = pend_g_q;
        pend_b_d       = pend_b_q;
        pending_d      = pending_q;
        period_start_d = w_boundary;

        // Accept needs ready, which implies an empty buffer, so it never
        // coincides with a boundary load; an accept on the boundary waits a period.
        if (w_accept) begin
            pend_r_d  = color_r_i;
            pend_g_d  = color_g_i;
            pend_b_d  = color_b_i;
            pending_d = 1'b1;
        end else if (w_boundary && pending_q) begin
            active_r_d = pend_r_q;
            active_g_d = pend_g_q;
            active_b_d = pend_b_q;
            pending_d  = 1'b0;
        end

        // Ready mirrors buffer emptiness, delayed so it first rises one edge after reset.
        ready_d = !pending_d;

        led_r_n_d = ~(enable_i && (pwm_cnt_q < active_r_q));
        led_g_n_d = ~(enable_i && (pwm_cnt_q < active_g_q));
        led_b_n_d = ~(enable_i && (pwm_cnt_q < active_b_q));
    end

    always_ff @(posedge clk_24MHz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prescaler_q    <= '0;
            pwm_cnt_q      <= '0;
            active_r_q     <= '0;
            active_g_q     <= '0;
            active_b_q     <= '0;
            pend_r_q       <= '0;
            pend_g_q       <= '0;
            pend_b_q       <= '0;
            pending_q      <= 1'b0;
            ready_q        <= 1'b0;
            period_start_q <= 1'b0;
            led_r_n_q      <= 1'b1;
            led_g_n_q      <= 1'b1;
            led_b_n_q      <= 1'b1;
        end else begin
            prescaler_q    <= prescaler_d;
            pwm_cnt_q      <= pwm_cnt_d;
            active_r_q     <= active_r_d;
            active_g_q     <= active_g_d;
            active_b_q     <= active_b_d;
            pend_r_q       <= pend_r_d;
            pend_g_q       <= pend_g_d;
            pend_b_q       <= pend_b_d;
            pending_q      <= pending_d;
            ready_q        <= ready_d;
            period_start_q <= period_start_d;
            led_r_n_q      <= led_r_n_d;
            led_g_n_q      <= led_g_n_d;
            led_b_n_q      <= led_b_n_d;
        end
    end

    assign color_ready_o  = ready_q;
    assign period_start_o = period_start_q;
    assign LED_R_n_o      = led_r_n_q;
    assign LED_G_n_o      = led_g_n_q;
    assign LED_B_n_o      = led_b_n_q;

endmodule

`default_nettype wire
